// File: rtl/dp4_ctrl_pkg.sv
// Shared types for the DP4 issue controller: FSM states, mode encodings and
// the shadow-pipeline entry that tracks each in-flight op.
package dp4_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2
  } state_e;

  localparam logic MODE_FP32 = 1'b1;
  localparam logic MODE_FP16 = 1'b0;

  localparam int DP4_TAG_W = 4;

  typedef struct packed {
    logic                 valid;
    logic                 src;
    logic [DP4_TAG_W-1:0] tag;
    logic                 mode;
  } shadow_t;

endpackage

// File: rtl/dp4_rr_arb2.sv
// Two-way round-robin winner select. The pointer names the preferred
// requester and moves to the loser whenever the winner is granted.
module dp4_rr_arb2 (
  input  logic clk,
  input  logic reset_n,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic grant_i,
  output logic winner_o
);

  logic rr_ptr_q, rr_ptr_d;

  always_comb begin
    winner_o = rr_ptr_q;
    if (rr_ptr_q == 1'b0) begin
      winner_o = valid0_i ? 1'b0 : 1'b1;
    end else begin
      winner_o = valid1_i ? 1'b1 : 1'b0;
    end
    rr_ptr_d = rr_ptr_q;
    if (grant_i) begin
      rr_ptr_d = ~winner_o;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/dp4_issue_ctrl.sv
// Issue controller for the shared DP4 datapath: arbitration, drain-before-mode-
// switch sequencing, shadow valid/tag pipeline and result-credit metering.
//
//   state  | meaning
//   RUN    | issuing ops whose mode matches dp_mode
//   DRAIN  | mismatch seen; waiting for in-flight ops to leave the pipe
//   SWITCH | pipe empty; dp_mode takes pend_mode this cycle
module dp4_issue_ctrl
  import dp4_ctrl_pkg::*;
#(
  parameter int PIPE_DEPTH = 4,
  parameter int TAG_W      = DP4_TAG_W,
  parameter int CREDITS    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic             req0_mode,
  input  logic [TAG_W-1:0] req0_tag,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_mode,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             req1_ready,
  output logic             dp_mode,
  output logic             dp_issue,
  output logic             dp_src,
  output logic [TAG_W-1:0] dp_tag,
  output logic             res_valid,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_mode,
  input  logic             res_credit_return,
  output logic             busy,
  output logic             credit_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [CW-1:0] CRED_ONE = CW'(1);

  state_e                  state_q, state_d;
  logic                    dp_mode_q, dp_mode_d;
  logic                    pend_mode_q, pend_mode_d;
  logic [CW-1:0]           cred_q, cred_d;
  logic                    credit_err_q, credit_err_d;
  shadow_t [PIPE_DEPTH-1:0] shadow_q, shadow_d;

  logic             winner;
  logic             win_valid;
  logic             win_mode;
  logic [TAG_W-1:0] win_tag;
  logic             accept;
  logic             any_inflight;
  logic             drain_done;

  dp4_rr_arb2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .grant_i  (accept),
    .winner_o (winner)
  );

  always_comb begin
    win_valid = winner ? req1_valid : req0_valid;
    win_mode  = winner ? req1_mode  : req0_mode;
    win_tag   = winner ? req1_tag   : req0_tag;
  end

  // drain_done looks one cycle ahead: only the last stage may still be valid,
  // so SWITCH lands on the first cycle the pipe is truly empty.
  always_comb begin
    any_inflight = 1'b0;
    drain_done   = 1'b1;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      any_inflight = any_inflight | shadow_q[i].valid;
      if (i != PIPE_DEPTH - 1) begin
        drain_done = drain_done & ~shadow_q[i].valid;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_mode_d = pend_mode_q;
    dp_mode_d   = dp_mode_q;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    case (state_q)
      RUN: begin
        if (win_valid) begin
          if (win_mode != dp_mode_q) begin
            pend_mode_d = win_mode;
            state_d     = drain_done ? SWITCH : DRAIN;
          end else if (cred_q != '0) begin
            accept     = 1'b1;
            req0_ready = ~winner;
            req1_ready = winner;
          end
        end
      end
      DRAIN: begin
        if (drain_done) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        dp_mode_d = pend_mode_q;
        state_d   = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    cred_d       = cred_q;
    credit_err_d = credit_err_q;
    if (accept && !res_credit_return) begin
      cred_d = cred_q - CRED_ONE;
    end else if (!accept && res_credit_return) begin
      if (cred_q == CRED_MAX) begin
        credit_err_d = 1'b1;
      end else begin
        cred_d = cred_q + CRED_ONE;
      end
    end
  end

  always_comb begin
    shadow_d[0].valid = accept;
    shadow_d[0].src   = winner;
    shadow_d[0].tag   = win_tag;
    shadow_d[0].mode  = dp_mode_q;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      shadow_d[i] = shadow_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= RUN;
      dp_mode_q    <= MODE_FP32;
      pend_mode_q  <= MODE_FP32;
      cred_q       <= CRED_MAX;
      credit_err_q <= 1'b0;
      shadow_q     <= '0;
    end else begin
      state_q      <= state_d;
      dp_mode_q    <= dp_mode_d;
      pend_mode_q  <= pend_mode_d;
      cred_q       <= cred_d;
      credit_err_q <= credit_err_d;
      shadow_q     <= shadow_d;
    end
  end

  assign dp_mode    = dp_mode_q;
  assign dp_issue   = accept;
  assign dp_src     = winner;
  assign dp_tag     = win_tag;
  assign res_valid  = shadow_q[PIPE_DEPTH-1].valid;
  assign res_src    = shadow_q[PIPE_DEPTH-1].src;
  assign res_tag    = shadow_q[PIPE_DEPTH-1].tag;
  assign res_mode   = shadow_q[PIPE_DEPTH-1].mode;
  assign busy       = any_inflight | (state_q != RUN);
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_dp4_issue_ctrl.sv
// Directed bench for dp4_issue_ctrl: cycle 0 is the first cycle after reset
// release; inputs change just after each rising edge and outputs are checked mid-cycle.
module tb_dp4_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req0_valid, req0_mode, req0_ready;
  logic [3:0] req0_tag;
  logic       req1_valid, req1_mode, req1_ready;
  logic [3:0] req1_tag;
  logic       dp_mode, dp_issue, dp_src;
  logic [3:0] dp_tag;
  logic       res_valid, res_src, res_mode;
  logic [3:0] res_tag;
  logic       res_credit_return;
  logic       busy, credit_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dp4_issue_ctrl #(.PIPE_DEPTH(4), .TAG_W(4), .CREDITS(4)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req0_valid        (req0_valid),
    .req0_mode         (req0_mode),
    .req0_tag          (req0_tag),
    .req0_ready        (req0_ready),
    .req1_valid        (req1_valid),
    .req1_mode         (req1_mode),
    .req1_tag          (req1_tag),
    .req1_ready        (req1_ready),
    .dp_mode           (dp_mode),
    .dp_issue          (dp_issue),
    .dp_src            (dp_src),
    .dp_tag            (dp_tag),
    .res_valid         (res_valid),
    .res_src           (res_src),
    .res_tag           (res_tag),
    .res_mode          (res_mode),
    .res_credit_return (res_credit_return),
    .busy              (busy),
    .credit_err        (credit_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v0, input logic m0, input logic [3:0] t0,
                       input logic v1, input logic m1, input logic [3:0] t1,
                       input logic ret);
    req0_valid = v0; req0_mode = m0; req0_tag = t0;
    req1_valid = v1; req1_mode = m1; req1_tag = t1;
    res_credit_return = ret;
  endtask

  task automatic do_reset();
    drive(0, 1, 0, 0, 1, 0, 0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    settle();
  endtask

  initial begin
    drive(0, 1, 0, 0, 1, 0, 0);

    // Reset values and FP32 stream
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_dp_mode", dp_mode, 1);
    chk("rst_dp_issue", dp_issue, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(); drive(1, 1, 4'(i), 0, 1, 0, 0); settle();
      chk("s32_issue", dp_issue, 1);
      chk("s32_ready0", req0_ready, 1);
      chk("s32_tag", dp_tag, i);
      chk("s32_src", dp_src, 0);
    end
    cyc(); drive(0, 1, 0, 0, 1, 0, 0); settle();
    chk("s32_res_c4", res_valid, 0);
    chk("s32_busy_c4", busy, 1);
    for (int i = 5; i <= 7; i++) begin
      cyc(); settle();
      chk("s32_res_valid", res_valid, 1);
      chk("s32_res_tag", res_tag, i - 4);
      chk("s32_res_mode", res_mode, 1);
      chk("s32_dp_mode", dp_mode, 1);
    end
    cyc(); settle();
    chk("s32_res_c8", res_valid, 0);
    chk("s32_idle_busy", busy, 0);

    // Round-robin and credit starvation
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1, 1, 4'hA, 1, 1, 4'hB, 0); settle();
      chk("rr_issue", dp_issue, 1);
      chk("rr_src", dp_src, i % 2);
      chk("rr_ready0", req0_ready, (i % 2) == 0);
      chk("rr_ready1", req1_ready, (i % 2) == 1);
      chk("rr_tag", dp_tag, ((i % 2) == 0) ? 32'hA : 32'hB);
    end
    for (int c = 5; c <= 9; c++) begin
      cyc(); settle();
      chk("starve_issue", dp_issue, 0);
      chk("starve_ready0", req0_ready, 0);
      chk("starve_ready1", req1_ready, 0);
    end
    cyc(); res_credit_return = 1'b1; settle();
    chk("ret_c10_issue", dp_issue, 0);
    cyc(); res_credit_return = 1'b0; settle();
    chk("ret_c11_issue", dp_issue, 1);
    chk("ret_c11_src", dp_src, 0);
    cyc(); settle();
    chk("ret_c12_issue", dp_issue, 0);

    // Return while full sets credit_err and does not raise the count
    do_reset();
    cyc(); drive(0, 1, 0, 0, 1, 0, 1); settle();
    chk("err_before", credit_err, 0);
    cyc(); drive(0, 1, 0, 0, 1, 0, 0); settle();
    chk("err_set", credit_err, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1, 1, 4'(i), 0, 1, 0, 0); settle();
      chk("err_issue", dp_issue, 1);
    end
    cyc(); settle();
    chk("err_cap_issue", dp_issue, 0);
    chk("err_sticky", credit_err, 1);

    // Issue and return in the same cycle leave the count unchanged
    do_reset();
    cyc(); drive(1, 1, 4'h1, 0, 1, 0, 0); settle();
    chk("sim_issue1", dp_issue, 1);
    cyc(); drive(1, 1, 4'h2, 0, 1, 0, 1); settle();
    chk("sim_issue2", dp_issue, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(); drive(1, 1, 4'(3 + i), 0, 1, 0, 0); settle();
      chk("sim_issue_rest", dp_issue, 1);
    end
    cyc(); settle();
    chk("sim_blocked", dp_issue, 0);
    chk("sim_no_err", credit_err, 0);

    // Mode switch with ops in flight
    do_reset();
    cyc(); settle();
    cyc(); drive(1, 1, 4'h5, 0, 0, 0, 0); settle();
    chk("ms_issue5", dp_issue, 1);
    chk("ms_tag5", dp_tag, 5);
    cyc(); drive(0, 1, 0, 1, 0, 4'h9, 0); settle();
    chk("ms_c3_ready1", req1_ready, 0);
    chk("ms_c3_issue", dp_issue, 0);
    for (int c = 4; c <= 5; c++) begin
      cyc(); settle();
      chk("ms_drain_ready1", req1_ready, 0);
      chk("ms_drain_busy", busy, 1);
      chk("ms_drain_mode", dp_mode, 1);
    end
    cyc(); settle();
    chk("ms_c6_res_valid", res_valid, 1);
    chk("ms_c6_res_tag", res_tag, 5);
    chk("ms_c6_res_mode", res_mode, 1);
    chk("ms_c6_ready1", req1_ready, 0);
    cyc(); settle();
    chk("ms_c7_res_valid", res_valid, 0);
    chk("ms_c7_ready1", req1_ready, 0);
    chk("ms_c7_busy", busy, 1);
    chk("ms_c7_issue", dp_issue, 0);
    cyc(); settle();
    chk("ms_c8_mode", dp_mode, 0);
    chk("ms_c8_ready1", req1_ready, 1);
    chk("ms_c8_issue", dp_issue, 1);
    chk("ms_c8_tag", dp_tag, 9);
    chk("ms_c8_src", dp_src, 1);
    cyc(); drive(0, 1, 0, 0, 0, 0, 0); settle();
    for (int c = 10; c <= 11; c++) begin
      cyc(); settle();
      chk("ms_gap_res", res_valid, 0);
    end
    cyc(); settle();
    chk("ms_c12_res_valid", res_valid, 1);
    chk("ms_c12_res_tag", res_tag, 9);
    chk("ms_c12_res_mode", res_mode, 0);
    chk("ms_c12_res_src", res_src, 1);

    // Mode switch from an empty pipe
    do_reset();
    cyc(); drive(1, 0, 4'h3, 0, 1, 0, 0); settle();
    chk("me_c1_ready0", req0_ready, 0);
    chk("me_c1_busy", busy, 0);
    cyc(); settle();
    chk("me_c2_busy", busy, 1);
    chk("me_c2_ready0", req0_ready, 0);
    chk("me_c2_mode", dp_mode, 1);
    cyc(); settle();
    chk("me_c3_mode", dp_mode, 0);
    chk("me_c3_issue", dp_issue, 1);
    chk("me_c3_ready0", req0_ready, 1);

    // Reset with three ops in flight while draining
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      cyc(); drive(1, 1, 4'(i), 0, 1, 0, 0); settle();
      chk("rm_issue", dp_issue, 1);
    end
    cyc(); drive(0, 1, 0, 1, 0, 4'h7, 0); settle();
    chk("rm_c4_issue", dp_issue, 0);
    cyc(); settle();
    chk("rm_c5_busy", busy, 1);
    chk("rm_c5_res_valid", res_valid, 1);
    drive(0, 1, 0, 0, 1, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("rm_rst_res_valid", res_valid, 0);
    chk("rm_rst_busy", busy, 0);
    chk("rm_rst_mode", dp_mode, 1);
    cyc(); settle();
    chk("rm_hold_res_valid", res_valid, 0);
    cyc(); reset_n = 1'b1; settle();
    for (int c = 0; c < 4; c++) begin
      cyc(); settle();
      chk("rm_post_res_valid", res_valid, 0);
      chk("rm_post_busy", busy, 0);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1, 1, 4'(i), 0, 1, 0, 0); settle();
      chk("rm_cred_issue", dp_issue, 1);
      chk("rm_cred_mode", dp_mode, 1);
    end
    cyc(); settle();
    chk("rm_cred_blocked", dp_issue, 0);
    drive(0, 1, 0, 0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
